// File: rtl/controle_multiciclo_pkg.sv
// pacote_controle: shared encodings for the multicycle main control unit.
//   - estado_t   : 4-bit state codes (also exported on the estado debug port)
//   - OP_*       : RISC-V opcodes decoded by the controller
//   - ULA_*      : op_ALU codes consumed by controle_ula
//   - SA_*/SB_*/RS_* : datapath mux select encodings
package pacote_controle;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ILEGAL   = 4'd9,
    S_EXECUTEI = 4'd10
  } estado_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;

  localparam logic [1:0] ULA_SOMA  = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_REGA  = 2'b10;

  localparam logic [1:0] SB_REGB = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_4    = 2'b10;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;

endpackage

// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if: control <-> datapath bundle.
//   master (controller): samples opcode/zero/mem_pronto, drives enables,
//   selects, op_ALU, instr_ilegal and estado.
//   slave (datapath/bench): the opposite directions.
interface controle_multiciclo_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_pronto;
  logic       pc_escreve;
  logic       ir_escreve;
  logic       mem_escreve;
  logic       reg_escreve;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] op_ALU;
  logic       instr_ilegal;
  logic [3:0] estado;

  modport master (
    input  opcode, zero, mem_pronto,
    output pc_escreve, ir_escreve, mem_escreve, reg_escreve, adr_src,
           alu_src_a, alu_src_b, result_src, op_ALU, instr_ilegal, estado
  );

  modport slave (
    output opcode, zero, mem_pronto,
    input  pc_escreve, ir_escreve, mem_escreve, reg_escreve, adr_src,
           alu_src_a, alu_src_b, result_src, op_ALU, instr_ilegal, estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle RISC-V main control FSM (lw, sw, R, beq).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (also gates all enables to 0 and
//          forces FETCH selects/estado combinationally while high)
//   bus  - controle_multiciclo_if.master: opcode/zero/mem_pronto in;
//          write enables, mux selects, op_ALU, instr_ilegal, estado out
// Optional feature: define CONTROLE_ADDI_EN to add EXECUTEI (addi).
module controle_multiciclo
  import pacote_controle::*;
(
  input logic                       clk,
  input logic                       rst,
  controle_multiciclo_if.master     bus
);

  estado_t st, nx, cur;

  logic       pc_w, ir_w, mem_w, reg_w, adr, ileg;
  logic [1:0] sa, sb, rs, op;

  always_ff @(posedge clk) begin
    if (rst) st <= S_FETCH;
    else     st <= nx;
  end

  always_comb begin
    // Reset overrides the registered state so outputs are clean even in the
    // first reset cycle and a write in progress is aborted.
    cur   = rst ? S_FETCH : st;
    nx    = st;
    pc_w  = 1'b0;
    ir_w  = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    adr   = 1'b0;
    ileg  = 1'b0;
    sa    = SA_PC;
    sb    = SB_REGB;
    rs    = RS_ALUOUT;
    op    = ULA_SOMA;
    case (cur)
      S_FETCH: begin
        sb   = SB_4;
        rs   = RS_ALURES;
        pc_w = bus.mem_pronto;
        ir_w = bus.mem_pronto;
        if (bus.mem_pronto) nx = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC+imm is computed here, ahead of the compare.
        sa = SA_OLDPC;
        sb = SB_IMM;
        case (bus.opcode)
          OP_LW, OP_SW: nx = S_MEMADR;
          OP_R:         nx = S_EXECUTER;
          OP_BEQ:       nx = S_BEQ;
`ifdef CONTROLE_ADDI_EN
          OP_I:         nx = S_EXECUTEI;
`endif
          default:      nx = S_ILEGAL;
        endcase
      end
      S_MEMADR: begin
        sa = SA_REGA;
        sb = SB_IMM;
        nx = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        if (bus.mem_pronto) nx = S_MEMWB;
      end
      S_MEMWB: begin
        rs    = RS_DATA;
        reg_w = 1'b1;
        nx    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        if (bus.mem_pronto) nx = S_FETCH;
      end
      S_EXECUTER: begin
        sa = SA_REGA;
        sb = SB_REGB;
        op = ULA_FUNCT;
        nx = S_ALUWB;
      end
`ifdef CONTROLE_ADDI_EN
      S_EXECUTEI: begin
        sa = SA_REGA;
        sb = SB_IMM;
        nx = S_ALUWB;
      end
`endif
      S_ALUWB: begin
        reg_w = 1'b1;
        nx    = S_FETCH;
      end
      S_BEQ: begin
        sa   = SA_REGA;
        sb   = SB_REGB;
        op   = ULA_SUB;
        pc_w = bus.zero;
        nx   = S_FETCH;
      end
      S_ILEGAL: begin
        ileg = 1'b1;
        nx   = S_FETCH;
      end
      default: nx = S_FETCH;
    endcase
    if (rst) begin
      pc_w = 1'b0;
      ir_w = 1'b0;
    end
  end

  assign bus.pc_escreve   = pc_w;
  assign bus.ir_escreve   = ir_w;
  assign bus.mem_escreve  = mem_w;
  assign bus.reg_escreve  = reg_w;
  assign bus.adr_src      = adr;
  assign bus.alu_src_a    = sa;
  assign bus.alu_src_b    = sb;
  assign bus.result_src   = rs;
  assign bus.op_ALU       = op;
  assign bus.instr_ilegal = ileg;
  assign bus.estado       = cur;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: table-driven check of controle_multiciclo.
// Each row is one clock cycle: inputs applied after the falling edge,
// outputs sampled 1 time unit later, state advances on the next rising edge.
// Expected word: {estado[3:0], pc, ir, mem, reg, adr, a[1:0], b[1:0],
//                 res[1:0], op[1:0], ilegal}.
module tb_controle_multiciclo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controle_multiciclo_if bus();
  controle_multiciclo dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        r;
    logic [6:0]  opc;
    logic        z;
    logic        mp;
    logic [17:0] ex;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [17:0] o(input logic [3:0] st, input logic pc,
      input logic ir, input logic mem, input logic rg, input logic adr,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] res,
      input logic [1:0] op, input logic il);
    return {st, pc, ir, mem, rg, adr, a, b, res, op, il};
  endfunction

  // Expected outputs per state, written straight from the state table.
  function automatic logic [17:0] e_fetch(input logic p);
    return o(4'd0, p, p, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_decode();
    return o(4'd1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_memadr();
    return o(4'd2, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_memread();
    return o(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_memwb();
    return o(4'd4, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_memwrite();
    return o(4'd5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_execr();
    return o(4'd6, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
  endfunction
  function automatic logic [17:0] e_aluwb();
    return o(4'd7, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_beq(input logic z);
    return o(4'd8, z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
  endfunction
  function automatic logic [17:0] e_ilegal();
    return o(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
  endfunction
  function automatic logic [17:0] e_execi();
    return o(4'd10, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
  endfunction

  task automatic add(input logic r, input logic [6:0] opc, input logic z,
                     input logic mp, input logic [17:0] ex);
    vec_t v;
    v.r = r; v.opc = opc; v.z = z; v.mp = mp; v.ex = ex;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] opc, input logic z,
                       input logic mp);
    @(negedge clk);
    rst = r; bus.opcode = opc; bus.zero = z; bus.mem_pronto = mp;
    #1;
  endtask

  function automatic logic [17:0] got();
    return {bus.estado, bus.pc_escreve, bus.ir_escreve, bus.mem_escreve,
            bus.reg_escreve, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
            bus.result_src, bus.op_ALU, bus.instr_ilegal};
  endfunction

  task automatic chk(input string name, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BQ = 7'b1100011, IL = 7'b1111111, AI = 7'b0010011;

  initial begin
    bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_pronto = 1'b1;

    // reset: 2 cycles, mem_pronto high must not leak into the enables
    add(1, LW, 0, 1, e_fetch(0));
    add(1, LW, 0, 1, e_fetch(0));
    // lw zero wait
    add(0, LW, 0, 1, e_fetch(1));
    add(0, LW, 0, 1, e_decode());
    add(0, LW, 0, 1, e_memadr());
    add(0, LW, 0, 1, e_memread());
    add(0, LW, 0, 1, e_memwb());
    // sw, mem_pronto in DECODE is ignored, 3 wait cycles in MEMWRITE
    add(0, SW, 0, 1, e_fetch(1));
    add(0, SW, 0, 1, e_decode());
    add(0, SW, 0, 0, e_memadr());
    add(0, SW, 0, 0, e_memwrite());
    add(0, SW, 0, 0, e_memwrite());
    add(0, SW, 0, 0, e_memwrite());
    add(0, SW, 0, 1, e_memwrite());
    // fetch wait, then R-type
    add(0, RT, 0, 0, e_fetch(0));
    add(0, RT, 0, 1, e_fetch(1));
    add(0, RT, 0, 0, e_decode());
    add(0, RT, 0, 0, e_execr());
    add(0, RT, 0, 0, e_aluwb());
    // beq taken / not taken
    add(0, BQ, 1, 1, e_fetch(1));
    add(0, BQ, 1, 1, e_decode());
    add(0, BQ, 1, 1, e_beq(1));
    add(0, BQ, 0, 1, e_fetch(1));
    add(0, BQ, 0, 1, e_decode());
    add(0, BQ, 0, 1, e_beq(0));
    // illegal opcode, back in FETCH on cycle 4
    add(0, IL, 0, 1, e_fetch(1));
    add(0, IL, 0, 1, e_decode());
    add(0, IL, 0, 1, e_ilegal());
    add(0, AI, 0, 1, e_fetch(1));
    add(0, AI, 0, 1, e_decode());
`ifdef CONTROLE_ADDI_EN
    add(0, AI, 0, 1, e_execi());
    add(0, AI, 0, 1, e_aluwb());
`else
    add(0, AI, 0, 1, e_ilegal());
`endif
    // reset in MEMREAD aborts lw
    add(0, LW, 0, 1, e_fetch(1));
    add(0, LW, 0, 1, e_decode());
    add(0, LW, 0, 0, e_memadr());
    add(1, LW, 0, 1, e_fetch(0));
    add(0, LW, 0, 0, e_fetch(0));
    // reset in MEMWB suppresses the register write
    add(0, LW, 0, 1, e_fetch(1));
    add(0, LW, 0, 1, e_decode());
    add(0, LW, 0, 1, e_memadr());
    add(0, LW, 0, 1, e_memread());
    add(1, LW, 0, 1, e_fetch(0));
    add(0, LW, 0, 1, e_fetch(1));
    add(0, LW, 0, 0, e_decode());
    add(1, LW, 0, 0, e_fetch(0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].opc, vecs[i].z, vecs[i].mp);
      nvec++;
      if (got() !== vecs[i].ex) begin
        nerr++;
        $display("FAIL vec%0d: got %h expected %h", i, got(), vecs[i].ex);
      end
    end

    // instr_ilegal is a single-cycle pulse with no writes around it
    begin
      int pulses = 0, writes = 0;
      drive(0, IL, 0, 1);
      for (int c = 0; c < 3; c++) begin
        if (c > 0) drive(0, IL, 0, 1);
        pulses += int'(bus.instr_ilegal);
        if (c > 0) writes += int'(bus.pc_escreve | bus.ir_escreve |
                                  bus.mem_escreve | bus.reg_escreve);
      end
      drive(0, IL, 0, 0);
      chk("ilegal_pulses", pulses, 1);
      chk("ilegal_writes", writes, 0);
      chk("ilegal_back_fetch", int'(bus.estado), 0);
    end

    // lw with random memory wait and reset in MEMREAD: reg_escreve never set
    begin
      int rw = 0, cyc = 0;
      drive(0, LW, 0, 1);
      while (bus.estado != 4'd3 && cyc < 20) begin
        drive(0, LW, 0, 0);
        cyc++;
        rw += int'(bus.reg_escreve);
      end
      chk("reach_memread", int'(bus.estado), 3);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        drive(0, LW, 0, 0);
        rw += int'(bus.reg_escreve);
      end
      drive(1, LW, 0, 1);
      rw += int'(bus.reg_escreve);
      drive(0, LW, 0, 0);
      rw += int'(bus.reg_escreve);
      chk("abort_estado", int'(bus.estado), 0);
      chk("abort_reg_escreve", rw, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle main control unit for the RISC-V datapath. It is a Moore FSM, with two Mealy-gated enables, that sequences fetch, decode, execute, memory and writeback for lw, sw, R-type and beq. Its `op_ALU` output drives the `op_ALU` input of `controle_ula`, so the ALU code is always derived downstream from this block's `op_ALU` plus the instruction's funct fields. It also drives mux selects and write enables in the datapath and waits on a memory-ready handshake.

## Interface
- No parameters.
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
  - `clk` input 1: single clock, rising edge.
  - `rst` input 1: synchronous, active-high reset.
- `opcode` input 7: `instr[6:0]` from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_pronto` input 1: memory completes the access this cycle.
- `pc_escreve` output 1: PC write enable.
- `ir_escreve` output 1: instruction register and OldPC write enable.
- `mem_escreve` output 1: memory write request.
- `reg_escreve` output 1: register file write enable.
- `adr_src` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `alu_src_a` output 2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = RegA.
- `alu_src_b` output 2: ALU operand B select. 00 = RegB, 01 = ImmExt, 10 = constant 4.
- `result_src` output 2: result bus select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `op_ALU` output 2: 00 = add, 01 = sub, 10 = use funct fields.
- `instr_ilegal` output 1: one-cycle pulse on an undecodable opcode.
- `estado` output 4: current state, for debug.

## Operation
States and their outputs. Any output not listed is 0 or 00.
- **FETCH**
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `op_ALU`=00, `result_src`=10.
  - `ir_escreve` = `pc_escreve` = `mem_pronto`.
  - Stays in FETCH while `mem_pronto`=0; goes to DECODE when `mem_pronto`=1.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `op_ALU`=00. This computes the branch target.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 1100011 → BEQ; anything else → ILEGAL.
- **MEMADR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `op_ALU`=00.
  - Next state: opcode 0000011 → MEMREAD; otherwise → MEMWRITE.
- **MEMREAD**
  - Outputs: `adr_src`=1, `result_src`=00.
  - Waits on `mem_pronto`, then → MEMWB.
- **MEMWB**
  - Outputs: `result_src`=01, `reg_escreve`=1.
  - Next state: FETCH.
- **MEMWRITE**
  - Outputs: `adr_src`=1, `result_src`=00, `mem_escreve`=1, held for the whole wait.
  - On `mem_pronto` → FETCH.
- **EXECUTER**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `op_ALU`=10.
  - Next state: ALUWB.
- **ALUWB**
  - Outputs: `result_src`=00, `reg_escreve`=1.
  - Next state: FETCH.
- **BEQ**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `op_ALU`=01, `result_src`=00.
  - `pc_escreve` = `zero`.
  - Next state: FETCH.
- **ILEGAL**
  - Outputs: `instr_ilegal`=1; no write enables.
  - Next state: FETCH.
- Mid-sequence rules:
  - `opcode` is sampled in DECODE and MEMADR. It must be stable because `ir_escreve`=0 outside FETCH.
  - Opcodes are never re-decoded mid-sequence.

## Timing
- Reset:
  - `rst`=1 at a rising edge → state FETCH.
  - While `rst`=1, all enables (`pc_escreve`, `ir_escreve`, `mem_escreve`, `reg_escreve`, `instr_ilegal`) are forced to 0.
  - Selects are forced to their FETCH values.
  - `estado` = FETCH code.
- Reset asserted mid-instruction aborts it: no register or memory write occurs in that cycle.
- Latency with zero wait, counted from entering FETCH:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - ILEGAL: 3 cycles.
- Each memory wait cycle adds 1 cycle in FETCH, MEMREAD or MEMWRITE.
- Mealy paths:
  - `pc_escreve` in FETCH (from `mem_pronto`) and in BEQ (from `zero`).
  - `ir_escreve` in FETCH (from `mem_pronto`).
  - All other outputs depend on state only.
- A `mem_pronto` that arrives in a non-memory state is ignored.

## Configuration
- `CONTROLE_ADDI_EN` defined:
  - Adds state EXECUTEI, entered from DECODE on opcode 0010011.
  - EXECUTEI outputs: `alu_src_a`=10, `alu_src_b`=01, `op_ALU`=00. Next state: ALUWB.
  - addi takes 4 cycles.
- `CONTROLE_ADDI_EN` undefined: opcode 0010011 goes to ILEGAL.

## Structure
- Shared package `pacote_controle` holds:
  - State encoding constants (4-bit).
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_BEQ, OP_I.
  - `op_ALU` constants: ULA_SOMA, ULA_SUB, ULA_FUNCT.
  - Encodings for the `alu_src_a`, `alu_src_b` and `result_src` selects.
- Single module with no sub-modules. `controle_ula` is instantiated alongside it at datapath level, not inside it.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then 0.
  - During reset: `estado`=FETCH and all enables 0.
  - First post-reset cycle with `mem_pronto`=1: `ir_escreve`=1 and `pc_escreve`=1.
- **lw, zero wait:** opcode 0000011, `mem_pronto`=1 always.
  - State sequence: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `reg_escreve`=1 only in cycle 5, with `result_src`=01.
- **sw with wait:** opcode 0100011, `mem_pronto`=0 for 3 cycles in MEMWRITE.
  - `mem_escreve`=1 for all 4 cycles in MEMWRITE.
  - Returns to FETCH after `mem_pronto`=1.
- **R-type and beq:**
  - R-type opcode 0110011: `op_ALU`=10 in EXECUTER.
  - beq with `zero`=1: `pc_escreve`=1 in BEQ.
  - beq with `zero`=0: `pc_escreve`=0 in BEQ.
- **Illegal opcode:** opcode 1111111.
  - `instr_ilegal`=1 for exactly 1 cycle, no writes, back in FETCH on cycle 4.
  - Repeat with opcode 0010011 with and without `CONTROLE_ADDI_EN`: ILEGAL when undefined, EXECUTEI then ALUWB when defined.
- **Reset mid-lw:** assert `rst` in MEMREAD.
  - Next state is FETCH and `reg_escreve` is never asserted.
